// File: rtl/window_buffer.sv
// Sliding sample window: fills DEPTH samples, then presents frozen windows
// every HOP_SIZE new samples, dropping and counting samples offered while held.
module window_buffer #(
  parameter int unsigned WINDOW_SIZE_BITS = 8,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned MAX_TAU          = 40,
  parameter int unsigned HOP_SIZE         = 128
) (
  input  logic                                                      clk,
  input  logic                                                      reset,
  input  logic [DATA_WIDTH-1:0]                                     sample_in,
  input  logic                                                      sample_valid,
  output logic                                                      sample_ready,
  input  logic                                                      window_done,
  output logic [DATA_WIDTH*((1 << WINDOW_SIZE_BITS) + MAX_TAU)-1:0] data_out,
  output logic                                                      window_valid,
  output logic                                                      start_pulse,
  output logic                                                      overrun,
  output logic [7:0]                                                drop_count
);

  localparam int unsigned DEPTH  = (1 << WINDOW_SIZE_BITS) + MAX_TAU;
  localparam int unsigned CW     = $clog2(DEPTH + 1);
  localparam int unsigned FLAT_W = DATA_WIDTH * DEPTH;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          drop;

  // Next-state and counter decode; sample_ready is itself a registered copy of (state != HOLD)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = sample_valid && sample_ready;
    drop    = sample_valid && !sample_ready;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_q == CW'(DEPTH - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOP: begin
        if (accept) begin
          if (cnt_q == CW'(HOP_SIZE - 1)) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (window_done) begin
          state_d = HOP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      sample_ready <= 1'b1;
      window_valid <= 1'b0;
      start_pulse  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sample_ready <= (state_d != HOLD);
      window_valid <= (state_d == HOLD);
      start_pulse  <= (state_d == HOLD) && (state_q != HOLD);
    end
  end

  // Shift toward slot 0 so slot 0 is always the oldest sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (accept) begin
      data_out <= {sample_in, data_out[FLAT_W-1:DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer at default parameters (DEPTH 296, HOP 128).
module tb_window_buffer;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 296;
  localparam int unsigned HOP   = 128;

  logic              clk;
  logic              reset;
  logic [DW-1:0]     sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              window_done;
  logic [DW*DEPTH-1:0] data_out;
  logic              window_valid;
  logic              start_pulse;
  logic              overrun;
  logic [7:0]        drop_count;

  int n_vec;
  int n_miss;

  window_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .window_done  (window_done),
    .data_out     (data_out),
    .window_valid (window_valid),
    .start_pulse  (start_pulse),
    .overrun      (overrun),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic          done;
    logic [DW-1:0] din;
    logic          exp_ready;
    logic          exp_wvalid;
    logic          exp_start;
    logic          exp_overrun;
    logic [7:0]    exp_drop;
    logic [DW-1:0] exp_newest;
  } vec_t;

  function automatic logic [DW-1:0] slot(input int k);
    return data_out[DW*k +: DW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_window(input string name, input int base);
    int bad;
    bad = 0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (slot(k) !== DW'(base + k)) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    reset        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    window_done  = 1'b0;

    // Hold table: starts in HOLD with no drops; row 4 is done+valid together
    tbl[0] = '{1'b1, 1'b0, 16'd999, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 16'd295};
    tbl[1] = '{1'b1, 1'b0, 16'd998, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 16'd295};
    tbl[2] = '{1'b1, 1'b0, 16'd997, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 16'd295};
    tbl[3] = '{1'b0, 1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 16'd295};
    tbl[4] = '{1'b1, 1'b1, 16'd777, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 16'd295};
    tbl[5] = '{1'b0, 1'b1, 16'd0,   1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 16'd295};

    #12;
    chk("rst_ready",   32'(sample_ready), 32'd1);
    chk("rst_wvalid",  32'(window_valid), 32'd0);
    chk("rst_start",   32'(start_pulse),  32'd0);
    chk("rst_overrun", 32'(overrun),      32'd0);
    chk("rst_drop",    32'(drop_count),   32'd0);
    chk("rst_slot295", 32'(slot(DEPTH-1)), 32'd0);
    #5 reset = 1'b1;
    step();

    // Initial fill 0..295 with a stray window_done on sample 100
    for (int i = 0; i < int'(DEPTH); i++) begin
      sample_valid = 1'b1;
      sample_in    = DW'(i);
      window_done  = (i == 100);
      step();
      if (i == 100) begin
        chk("stray_done_wvalid", 32'(window_valid), 32'd0);
        chk("stray_done_ready",  32'(sample_ready), 32'd1);
      end
      if (i == int'(DEPTH) - 2) chk("fill_wvalid_early", 32'(window_valid), 32'd0);
    end
    sample_valid = 1'b0;
    window_done  = 1'b0;
    chk("fill_wvalid",  32'(window_valid), 32'd1);
    chk("fill_start",   32'(start_pulse),  32'd1);
    chk("fill_ready",   32'(sample_ready), 32'd0);
    chk("fill_slot0",   32'(slot(0)),      32'd0);
    chk("fill_slot295", 32'(slot(DEPTH-1)), 32'd295);
    check_window("fill_window", 0);
    step();
    chk("fill_start_once", 32'(start_pulse),  32'd0);
    chk("fill_hold",       32'(window_valid), 32'd1);

    // Table: drops in HOLD, then simultaneous done+valid, then done ignored in HOP
    for (int v = 0; v < 6; v++) begin
      sample_valid = tbl[v].valid;
      window_done  = tbl[v].done;
      sample_in    = tbl[v].din;
      step();
      chk($sformatf("tbl%0d_ready", v),   32'(sample_ready),   32'(tbl[v].exp_ready));
      chk($sformatf("tbl%0d_wvalid", v),  32'(window_valid),   32'(tbl[v].exp_wvalid));
      chk($sformatf("tbl%0d_start", v),   32'(start_pulse),    32'(tbl[v].exp_start));
      chk($sformatf("tbl%0d_overrun", v), 32'(overrun),        32'(tbl[v].exp_overrun));
      chk($sformatf("tbl%0d_drop", v),    32'(drop_count),     32'(tbl[v].exp_drop));
      chk($sformatf("tbl%0d_newest", v),  32'(slot(DEPTH-1)),  32'(tbl[v].exp_newest));
    end
    window_done = 1'b0;
    chk("hold_slot0", 32'(slot(0)), 32'd0);

    // Hop: 128 samples 296..423
    for (int i = 0; i < int'(HOP); i++) begin
      sample_valid = 1'b1;
      sample_in    = DW'(int'(DEPTH) + i);
      step();
      if (i == int'(HOP) - 2) chk("hop_wvalid_early", 32'(window_valid), 32'd0);
    end
    sample_valid = 1'b0;
    chk("hop_wvalid",  32'(window_valid), 32'd1);
    chk("hop_start",   32'(start_pulse),  32'd1);
    chk("hop_slot0",   32'(slot(0)),      32'd128);
    chk("hop_slot295", 32'(slot(DEPTH-1)), 32'd423);
    check_window("hop_window", 128);

    // Saturation: 300 more drops
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1;
      sample_in    = 16'hBEEF;
      step();
    end
    sample_valid = 1'b0;
    chk("sat_drop",    32'(drop_count),    32'd255);
    chk("sat_slot295", 32'(slot(DEPTH-1)), 32'd423);

    // Reset mid-HOP after 50 samples, asserted between clock edges
    window_done = 1'b1;
    step();
    window_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample_valid = 1'b1;
      sample_in    = DW'(500 + i);
      step();
    end
    sample_valid = 1'b0;
    chk("prerst_slot295", 32'(slot(DEPTH-1)), 32'd549);
    #2 reset = 1'b0;
    #1;
    chk("async_overrun", 32'(overrun),       32'd0);
    chk("async_drop",    32'(drop_count),    32'd0);
    chk("async_slot295", 32'(slot(DEPTH-1)), 32'd0);
    chk("async_slot0",   32'(slot(0)),       32'd0);
    chk("async_ready",   32'(sample_ready),  32'd1);
    chk("async_wvalid",  32'(window_valid),  32'd0);
    #3 reset = 1'b1;
    step();

    for (int i = 0; i < int'(DEPTH); i++) begin
      sample_valid = 1'b1;
      sample_in    = DW'(1000 + i);
      step();
      if (i == int'(HOP) - 1) chk("post_rst_no_hop", 32'(window_valid), 32'd0);
      if (i == int'(DEPTH) - 2) chk("post_rst_wvalid_early", 32'(window_valid), 32'd0);
    end
    sample_valid = 1'b0;
    chk("post_rst_wvalid",  32'(window_valid), 32'd1);
    chk("post_rst_start",   32'(start_pulse),  32'd1);
    chk("post_rst_slot0",   32'(slot(0)),      32'd1000);
    chk("post_rst_slot295", 32'(slot(DEPTH-1)), 32'd1295);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter WINDOW_SIZE_BITS, default 8: log2 of the analysis window length.
REQ-002 Parameter DATA_WIDTH, default 16: sample width in bits.
REQ-003 Parameter MAX_TAU, default 40: extra lag samples held beyond the window.
REQ-004 Parameter HOP_SIZE, default 128: new samples between successive windows, 1 <= HOP_SIZE <= DEPTH.
REQ-005 Derived constant DEPTH SHALL equal 2**WINDOW_SIZE_BITS + MAX_TAU (296 at defaults).
REQ-006 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 reset  input  1  asynchronous, active-low; 0 = in reset.
REQ-009 sample_in  input  DATA_WIDTH  incoming audio sample.
REQ-010 sample_valid  input  1  sample_in is valid this cycle.
REQ-011 sample_ready  output  1  block accepts a sample this cycle.
REQ-012 window_done  input  1  consumer has finished the current window.
REQ-013 data_out  output  DATA_WIDTH*DEPTH  flat window; slot k is bits [DATA_WIDTH*k +: DATA_WIDTH]; slot 0 oldest, slot DEPTH-1 newest.
REQ-014 window_valid  output  1  data_out holds a complete, frozen window.
REQ-015 start_pulse  output  1  one-cycle pulse on window_valid rising; used to clear downstream accumulators.
REQ-016 overrun  output  1  sticky flag: at least one sample was dropped.
REQ-017 drop_count  output  8  saturating count of dropped samples.

Function
REQ-018 States SHALL be FILL, HOP and HOLD, with a sample counter wide enough to count to DEPTH.
REQ-019 Acceptance SHALL occur on a rising edge where sample_valid=1 and sample_ready=1.
REQ-020 sample_ready SHALL be 1 in FILL and HOP and 0 in HOLD; it is decoded from the registered state only.
REQ-021 On acceptance, slot k SHALL take slot k+1 for k = 0..DEPTH-2, and slot DEPTH-1 SHALL take sample_in; the new data is visible on data_out the cycle after acceptance.
REQ-022 FILL: the counter increments per acceptance; the DEPTH-th acceptance SHALL move the block to HOLD.
REQ-023 HOP: the counter increments per acceptance; the HOP_SIZE-th acceptance SHALL move the block to HOLD.
REQ-024 HOLD: window_valid=1 and data_out is frozen; window_done=1 SHALL move the block to HOP with the counter at 0.
REQ-025 window_valid SHALL rise the cycle after the completing acceptance; start_pulse SHALL be 1 for that same single cycle only.
REQ-026 window_done outside HOLD SHALL be ignored, with no state, counter or flag change.
REQ-027 Drop rule: sample_valid=1 with sample_ready=0 SHALL leave the data unchanged, set overrun, and increment drop_count, saturating at 255.
REQ-028 If window_done and sample_valid are both 1 in HOLD, the sample SHALL be dropped per REQ-027 and the transition to HOP SHALL still occur.
REQ-029 overrun and drop_count SHALL clear only on reset.

Reset
REQ-030 While reset=0, all slots SHALL be 0, state FILL, counter 0, and window_valid, start_pulse, overrun and drop_count all 0; sample_ready SHALL be 1.
REQ-031 Reset asserted mid-FILL, mid-HOP or mid-HOLD SHALL discard all window contents immediately (asynchronously); the first window after reset requires DEPTH fresh samples.

Verification
REQ-032 Fill: after reset, accept 296 samples with values 0..295 back-to-back -> next cycle window_valid=1 and start_pulse=1 for one cycle, slot0=0, slot295=295, sample_ready=0.
REQ-033 Hop: from REQ-032, pulse window_done, then feed 296..423 -> window_valid falls, rises again after the 128th sample, slot0=128, slot295=423.
REQ-034 Overrun: in HOLD, drive sample_valid for 3 cycles -> data_out unchanged, overrun=1, drop_count=3; 300 drops -> drop_count=255.
REQ-035 Simultaneous: window_done and sample_valid high in the same HOLD cycle -> state HOP next cycle, drop_count increments by 1, sample not stored.
REQ-036 Reset mid-HOP after 50 samples: pull reset low asynchronously between edges -> outputs clear without a clock edge; 296 new samples are needed before window_valid.
REQ-037 Stray window_done in FILL at sample 100 -> no effect; window_valid still rises after sample 296.
